// File: rtl/gsensor_pkg.sv
// Purpose: shared register map, frame bit positions, FSM states and helpers for the gsensor SPI secondary.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gsensor_pkg;

    // Register map (6-bit address space, 64 registers)
    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    // Status/data window that the primary may read but never write
    localparam logic [5:0] ADDR_RO_LO = 6'h30;
    localparam logic [5:0] ADDR_RO_HI = 6'h39;

    // Command byte layout: {RW, MB, A[5:0]}
    localparam int RW_BIT = 7;
    localparam int MB_BIT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    function automatic logic is_read_only(input logic [5:0] addr);
        return (addr == ADDR_DEVID) || ((addr >= ADDR_RO_LO) && (addr <= ADDR_RO_HI));
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Purpose: WIDTH-bit 2-flop synchroniser with registered rise/fall strobes and an edge-aligned level.
// Latency: strobes and level_o lag the pin by 3 clk.
// Backpressure: none; strobes are single-cycle and must be consumed when asserted.
//
// Ports: clk_i, rst_ni (async active-low), d_i (async pins),
//        lvl_o (synchronised level, aligned with the strobes), rise_o / fall_o (1-clk edge strobes).
module spi_sync_edge #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] lvl_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] lvl_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    // Reset value matches the idle pin level so no spurious edge is seen after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            lvl_q  <= RESET_VAL;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            lvl_q  <= sync_q;
            rise_q <= sync_q & ~lvl_q;
            fall_q <= ~sync_q & lvl_q;
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/gsensor_spi_secondary.sv
// Purpose: ADXL345-style SPI secondary (CPOL=1/CPHA=1) with a 64x8 register file and axis sample ports.
// Latency: every SPI pin event acts 3 clk after the pin; SDO updates 4 clk after a falling SPI_CLK.
// Backpressure: none; samples arriving mid-frame are held and applied 1 clk after CSN rises.
//
// Ports: clk, reset_n (async active-low); SPI_CLK/SPI_CSN/SPI_SDI in, SPI_SDO out;
//        sample_x/y/z + sample_valid load DATAX0..DATAZ1; wr_valid/wr_addr/wr_data report
//        each accepted register write; busy is high while the synchronised CSN is low.
module gsensor_spi_secondary #(
    parameter int         CLK_FREQUENCY = 16_000_000,
    parameter int         SPI_FREQUENCY = 2_000_000,
    parameter logic [7:0] DEVID_VALUE   = 8'hE5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SPI_CLK,
    input  logic        SPI_CSN,
    input  logic        SPI_SDI,
    output logic        SPI_SDO,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic        wr_valid,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);
    import gsensor_pkg::*;

    // A half SPI period must span at least 4 clk to absorb the 3-clk sync lag plus the SDO register.
    if (CLK_FREQUENCY < 8 * SPI_FREQUENCY) begin : g_freq_check
        $error("CLK_FREQUENCY must be at least 8 * SPI_FREQUENCY");
    end

    logic [2:0] pin_lvl, pin_rise, pin_fall;

    spi_sync_edge #(.WIDTH(3), .RESET_VAL(3'b110)) u_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    ({SPI_CLK, SPI_CSN, SPI_SDI}),
        .lvl_o  (pin_lvl),
        .rise_o (pin_rise),
        .fall_o (pin_fall)
    );

    logic sck_lvl, sck_rise, sck_fall, csn_rise, csn_fall, sdi;
    assign sck_lvl  = pin_lvl[2];
    assign sck_rise = pin_rise[2];
    assign sck_fall = pin_fall[2];
    assign csn_rise = pin_rise[1];
    assign csn_fall = pin_fall[1];
    assign sdi      = pin_lvl[0];

    logic unused_pins;
    assign unused_pins = ^{pin_lvl[1], pin_rise[0], pin_fall[0]};

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  rx_q;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_q;
    logic        rw_q, mb_q;
    logic [5:0]  addr_q, addr_next;
    logic        sdo_q;
    logic        wr_valid_q;
    logic [5:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        busy_q;
    logic        pend_q;
    logic [47:0] hold_q;
    logic [7:0]  regs_q [64];

    logic        shift_en, cmd_done, data_done, drive_en;
    logic        load_en;
    logic [47:0] load_dat;

    assign rx_byte   = {rx_q, sdi};
    assign addr_next = mb_q ? addr_q + 6'd1 : addr_q;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state; CSN rising aborts from anywhere, discarding a partial byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (csn_fall) state_d = sck_lvl ? CMD : ERR;
            CMD:     if (sck_rise && (bit_cnt_q == 3'd7)) state_d = DATA;
            default: state_d = state_q;
        endcase
        if (csn_rise) state_d = IDLE;
    end

    // FSM outputs
    always_comb begin
        shift_en  = sck_rise && ((state_q == CMD) || (state_q == DATA));
        cmd_done  = shift_en && (bit_cnt_q == 3'd7) && (state_q == CMD);
        data_done = shift_en && (bit_cnt_q == 3'd7) && (state_q == DATA);
        drive_en  = (state_q == DATA) && rw_q && !csn_rise;
    end

    // Samples go straight in while idle; while busy they wait in hold_q so a burst read stays coherent.
    always_comb begin
        load_en  = 1'b0;
        load_dat = {sample_z, sample_y, sample_x};
        if (sample_valid && !busy_q) begin
            load_en = 1'b1;
        end else if (!sample_valid && pend_q && !busy_q) begin
            load_en  = 1'b1;
            load_dat = hold_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            rw_q       <= 1'b0;
            mb_q       <= 1'b0;
            addr_q     <= '0;
            sdo_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
            hold_q     <= '0;
            for (int i = 0; i < 64; i++) regs_q[i] <= (i == 0) ? DEVID_VALUE : 8'h00;
        end else begin
            wr_valid_q <= 1'b0;

            if (csn_fall)      busy_q <= 1'b1;
            else if (csn_rise) busy_q <= 1'b0;

            if ((state_q == IDLE) && csn_fall) bit_cnt_q <= '0;

            if (shift_en) begin
                rx_q      <= rx_byte[6:0];
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if (cmd_done) begin
                rw_q   <= rx_byte[RW_BIT];
                mb_q   <= rx_byte[MB_BIT];
                addr_q <= rx_byte[5:0];
                tx_q   <= regs_q[rx_byte[5:0]];
            end

            if (data_done) begin
                if (!rw_q && !is_read_only(addr_q)) begin
                    regs_q[addr_q] <= rx_byte;
                    wr_valid_q     <= 1'b1;
                    wr_addr_q      <= addr_q;
                    wr_data_q      <= rx_byte;
                end
                addr_q <= addr_next;
                tx_q   <= regs_q[addr_next];
            end

            if (drive_en && sck_fall) begin
                sdo_q <= tx_q[7];
                tx_q  <= {tx_q[6:0], 1'b0};
            end else if (!drive_en) begin
                sdo_q <= 1'b0;
            end

            if (sample_valid && busy_q) begin
                hold_q <= {sample_z, sample_y, sample_x};
                pend_q <= 1'b1;
            end else if (load_en) begin
                pend_q <= 1'b0;
            end

            if (load_en) begin
                regs_q[ADDR_DATAX0] <= load_dat[7:0];
                regs_q[ADDR_DATAX1] <= load_dat[15:8];
                regs_q[ADDR_DATAY0] <= load_dat[23:16];
                regs_q[ADDR_DATAY1] <= load_dat[31:24];
                regs_q[ADDR_DATAZ0] <= load_dat[39:32];
                regs_q[ADDR_DATAZ1] <= load_dat[47:40];
            end
        end
    end

    assign SPI_SDO  = sdo_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_gsensor_spi_secondary.sv
// Purpose: self-checking bench for gsensor_spi_secondary: vector table, corner-case sequences, random frames.
// Latency: SPI half period is HALF clk, comfortably above the responder's 4-clk SDO lag.
// Backpressure: not applicable; the bench is the SPI primary.
module tb_gsensor_spi_secondary;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck = 1'b1;
    logic        csn = 1'b1;
    logic        sdi = 1'b0;
    logic        sdo;
    logic [15:0] sx = '0, sy = '0, sz = '0;
    logic        sv = 1'b0;
    logic        wr_valid;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    always #5 clk = ~clk;

    gsensor_spi_secondary #(
        .CLK_FREQUENCY(16_000_000),
        .SPI_FREQUENCY(2_000_000),
        .DEVID_VALUE  (8'hE5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .SPI_CLK     (sck),
        .SPI_CSN     (csn),
        .SPI_SDI     (sdi),
        .SPI_SDO     (sdo),
        .sample_x    (sx),
        .sample_y    (sy),
        .sample_z    (sz),
        .sample_valid(sv),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] act_wr[$];
    logic [13:0] exp_wr[$];

    // Every high cycle of wr_valid is one write; a stretched pulse shows up as an extra entry.
    always @(negedge clk) if (reset_n && wr_valid) act_wr.push_back({wr_addr, wr_data});

    logic [7:0] wbytes [8];
    logic [7:0] rbytes [8];
    logic [7:0] exp_rd [8];
    logic [7:0] cmd_rx;
    int         pulse_after = -1;
    logic [15:0] px, py, pz;
    bit          busy_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        sx = x; sy = y; sz = z; sv = 1'b1;
        wait_clks(1);
        sv = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] dout, input int nbits, output logic [7:0] din);
        din = '0;
        for (int b = 0; b < nbits; b++) begin
            sck = 1'b0;
            sdi = dout[7-b];
            wait_clks(HALF);
            din = {din[6:0], sdo};
            busy_seen |= busy;
            sck = 1'b1;
            wait_clks(HALF);
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int n, input int last_bits, input bit err_start);
        logic [7:0] rx;
        busy_seen = 1'b0;
        if (err_start) begin
            sck = 1'b0;
            wait_clks(HALF);
        end
        csn = 1'b0;
        wait_clks(HALF);
        xfer(cmd, 8, rx);
        cmd_rx = rx;
        for (int i = 0; i < n; i++) begin
            xfer(wbytes[i], (i == n - 1) ? last_bits : 8, rx);
            rbytes[i] = rx;
            if (i == pulse_after) pulse_sample(px, py, pz);
        end
        sck = 1'b1;
        wait_clks(HALF);
        csn = 1'b1;
        wait_clks(3 * HALF);
    endtask

    task automatic check_writes(input string name);
        check({name, "_nwr"}, act_wr.size(), exp_wr.size());
        if (act_wr.size() == exp_wr.size())
            for (int i = 0; i < act_wr.size(); i++)
                check($sformatf("%s_wr%0d", name, i), {18'h0, act_wr[i]}, {18'h0, exp_wr[i]});
        act_wr.delete();
        exp_wr.delete();
    endtask

    // Reference model: a plain register array walked byte by byte.
    logic [7:0] mregs [64];

    function automatic bit m_ro(input logic [5:0] a);
        return (a == 6'h00) || (a >= 6'h30 && a <= 6'h39);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
        mregs[0] = 8'hE5;
    endtask

    task automatic model_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        mregs[6'h32] = x[7:0];  mregs[6'h33] = x[15:8];
        mregs[6'h34] = y[7:0];  mregs[6'h35] = y[15:8];
        mregs[6'h36] = z[7:0];  mregs[6'h37] = z[15:8];
    endtask

    task automatic model_frame(input logic [7:0] cmd, input int n);
        logic [5:0] a;
        a = cmd[5:0];
        for (int k = 0; k < n; k++) begin
            if (cmd[7]) exp_rd[k] = mregs[a];
            else if (!m_ro(a)) begin
                mregs[a] = wbytes[k];
                exp_wr.push_back({a, wbytes[k]});
            end
            if (cmd[6]) a = a + 6'd1;
        end
    endtask

    typedef struct {
        bit          do_sample;
        logic [15:0] vx, vy, vz;
        logic [7:0]  cmd;
        int          n;
        logic [47:0] wd;
        logic [47:0] rd;
        int          nwr;
        logic [5:0]  wa;
        logic [7:0]  wdv;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [7:0] rx;
        logic [7:0] cmd;
        int         n;

        vecs[0] = '{1'b0, 16'h0, 16'h0, 16'h0, 8'h80, 1, 48'h0, 48'hE5_00_00_00_00_00, 0, 6'h00, 8'h00};
        vecs[1] = '{1'b0, 16'h0, 16'h0, 16'h0, 8'h2D, 1, 48'h08_00_00_00_00_00, 48'h0, 1, 6'h2D, 8'h08};
        vecs[2] = '{1'b0, 16'h0, 16'h0, 16'h0, 8'hAD, 1, 48'h0, 48'h08_00_00_00_00_00, 0, 6'h00, 8'h00};
        vecs[3] = '{1'b1, 16'h1234, 16'hFF80, 16'h0100, 8'hF2, 6, 48'h0, 48'h34_12_80_FF_00_01, 0, 6'h00, 8'h00};
        vecs[4] = '{1'b0, 16'h0, 16'h0, 16'h0, 8'h32, 1, 48'h55_00_00_00_00_00, 48'h0, 0, 6'h00, 8'h00};
        vecs[5] = '{1'b0, 16'h0, 16'h0, 16'h0, 8'hB2, 2, 48'h0, 48'h34_34_00_00_00_00, 0, 6'h00, 8'h00};
        vecs[6] = '{1'b0, 16'h0, 16'h0, 16'h0, 8'h6E, 2, 48'hAB_CD_00_00_00_00, 48'h0, 2, 6'h2F, 8'hCD};
        vecs[7] = '{1'b0, 16'h0, 16'h0, 16'h0, 8'hEE, 3, 48'h0, 48'hAB_CD_00_00_00_00, 0, 6'h00, 8'h00};

        // Reset values
        wait_clks(4);
        check("rst_sdo", sdo, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        wait_clks(HALF);

        // Vector table
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].do_sample) begin
                pulse_sample(vecs[v].vx, vecs[v].vy, vecs[v].vz);
                wait_clks(2);
            end
            for (int k = 0; k < 6; k++) wbytes[k] = vecs[v].wd[47-8*k -: 8];
            run_frame(vecs[v].cmd, vecs[v].n, 8, 1'b0);
            check($sformatf("v%0d_cmd_sdo", v), cmd_rx, 0);
            check($sformatf("v%0d_busy_in", v), busy_seen, 1);
            check($sformatf("v%0d_busy_out", v), busy, 0);
            if (vecs[v].cmd[7])
                for (int k = 0; k < vecs[v].n; k++)
                    check($sformatf("v%0d_rd%0d", v, k), rbytes[k], vecs[v].rd[47-8*k -: 8]);
            check($sformatf("v%0d_nwr", v), act_wr.size(), vecs[v].nwr);
            if (vecs[v].nwr > 0 && act_wr.size() > 0)
                check($sformatf("v%0d_lastwr", v), {18'h0, act_wr[act_wr.size()-1]}, {18'h0, vecs[v].wa, vecs[v].wdv});
            act_wr.delete();
        end

        // Coherence: new sample mid-burst is deferred until CSN rises
        px = 16'hAAAA; py = 16'hFF80; pz = 16'h0100;
        pulse_after = 1;
        run_frame(8'hF2, 6, 8, 1'b0);
        pulse_after = -1;
        check("coh_old_b2", rbytes[2], 8'h80);
        check("coh_old_b0", rbytes[0], 8'h34);
        check("coh_old_b5", rbytes[5], 8'h01);
        run_frame(8'hF2, 6, 8, 1'b0);
        check("coh_new_b0", rbytes[0], 8'hAA);
        check("coh_new_b1", rbytes[1], 8'hAA);
        check("coh_new_b2", rbytes[2], 8'h80);

        // Abort and wrap: 0x3F written, 0x00 skipped, partial third byte dropped
        wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33;
        exp_wr.push_back({6'h3F, 8'h11});
        run_frame(8'h7F, 3, 4, 1'b0);
        check_writes("abort");
        run_frame(8'hFF, 2, 8, 1'b0);
        check("wrap_3f", rbytes[0], 8'h11);
        check("wrap_devid", rbytes[1], 8'hE5);
        run_frame(8'h81, 1, 8, 1'b0);
        check("abort_no_third", rbytes[0], 8'h00);

        // CSN falling with SPI_CLK low: whole frame ignored
        wbytes[0] = 8'h77;
        run_frame(8'h2D, 1, 8, 1'b1);
        check_writes("err_frame");
        check("err_busy", busy_seen, 1);
        run_frame(8'hAD, 1, 8, 1'b0);
        check("err_kept", rbytes[0], 8'h08);

        // Reset mid-frame
        csn = 1'b0;
        wait_clks(HALF);
        xfer(8'h2D, 8, rx);
        xfer(8'h77, 4, rx);
        check("midrst_busy", busy, 1);
        reset_n = 1'b0;
        wait_clks(2);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_busy0", busy, 0);
        check("midrst_sdo", sdo, 0);
        sck = 1'b1; csn = 1'b1;
        wait_clks(2);
        reset_n = 1'b1;
        wait_clks(HALF);
        act_wr.delete();
        run_frame(8'hAD, 1, 8, 1'b0);
        check("midrst_reg2d", rbytes[0], 8'h00);
        run_frame(8'hBF, 1, 8, 1'b0);
        check("midrst_reg3f", rbytes[0], 8'h00);
        check_writes("midrst");

        // Random frames against the model
        model_reset();
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                px = 16'($urandom); py = 16'($urandom); pz = 16'($urandom);
                pulse_sample(px, py, pz);
                model_sample(px, py, pz);
                wait_clks(2);
            end
            cmd = 8'($urandom);
            if ($urandom_range(0, 1) == 1) cmd[5:0] = 6'(6'h2C + $urandom_range(0, 12));
            n = int'($urandom_range(0, 4));
            for (int k = 0; k < 8; k++) wbytes[k] = 8'($urandom);
            model_frame(cmd, n);
            run_frame(cmd, n, 8, 1'b0);
            if (cmd[7])
                for (int k = 0; k < n; k++)
                    check($sformatf("rand%0d_rd%0d", t, k), rbytes[k], exp_rd[k]);
            check_writes($sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1);
    end

endmodule
